// File: rtl/slow_mem_arb_pkg.sv
// Shared types and constants for the slow-memory arbiter.
// The state encoding is fixed so the debug state output is stable across builds.
package slow_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/slow_mem_arbiter_rr_picker.sv
// Combinational winner selection: rotating priority from ptr_i, or fixed
// priority (channel 0 highest) when fixed_i is set.
module rr_picker #(
    parameter int  N_CH = 2,
    localparam int PW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    input  logic            fixed_i,
    output logic [N_CH-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    logic [PW-1:0]     base;
    logic [2*N_CH-1:0] dbl;
    logic [2*N_CH-1:0] masked;
    logic              found;

    assign base  = fixed_i ? '0 : ptr_i;
    assign dbl   = {req_i, req_i};
    assign any_o = |req_i;

    // The upper copy of the request vector supplies the wrapped-around
    // channels once everything below the pointer has been masked off.
    always_comb begin
        masked = '0;
        found  = 1'b0;
        idx_o  = '0;
        gnt_o  = '0;
        for (int i = 0; i < 2 * N_CH; i++) begin
            masked[i] = dbl[i] && (i >= int'(base));
        end
        for (int i = 0; i < 2 * N_CH; i++) begin
            if (masked[i] && !found) begin
                found = 1'b1;
                idx_o = PW'(i % N_CH);
            end
        end
        if (found) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/slow_mem_arbiter.sv
// N-channel arbiter sharing one slow-memory port among cache requesters.
// Handshake: requests are held until a one-cycle ch_ready; mem_ready is a one-cycle completion.
module slow_mem_arbiter
    import slow_mem_arb_pkg::*;
#(
    parameter int  N_CH   = 2,
    parameter int  ADDR_W = 28,
    parameter int  DATA_W = 128,
    parameter int  MODE   = 0,
    localparam int GW     = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          ch_read,
    input  logic [N_CH-1:0]          ch_write,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_wdata,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [N_CH-1:0]          ch_ready,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic [GW-1:0]            grant_id,
    output logic                     busy,
    output logic                     proto_err,
    output logic [1:0]               dbg_state
);

    arb_state_e        state_q, state_d;
    logic [GW-1:0]     gid_q, gid_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              perr_q, perr_d;

    logic [N_CH-1:0]   req_vec;
    logic [N_CH-1:0]   win_oh;
    logic [GW-1:0]     win_idx;
    logic              win_any;

    assign req_vec = ch_read | ch_write;

    rr_picker #(.N_CH(N_CH)) u_picker (
        .req_i   (req_vec),
        .ptr_i   (ptr_q),
        .fixed_i (MODE == ARB_FIXED),
        .gnt_o   (win_oh),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        perr_d  = perr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    gid_d   = win_idx;
                    addr_d  = ch_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    wdata_d = ch_wdata[int'(win_idx)*DATA_W +: DATA_W];
                    // Read+write together resolves to a write and flags the requester.
                    wr_d    = |(ch_write & win_oh);
                    perr_d  = perr_q | (|(ch_read & ch_write & win_oh));
                    if (MODE == ARB_RR) begin
                        ptr_d = (win_idx == GW'(N_CH - 1)) ? '0 : win_idx + 1'b1;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gid_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            perr_q  <= perr_d;
        end
    end

    // Outputs decode registered state only, so an async reset drops them at once.
    assign mem_read  = (state_q == ST_ISSUE) && !wr_q;
    assign mem_write = (state_q == ST_ISSUE) && wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ch_rdata  = rdata_q;
    assign ch_ready  = (state_q == ST_RESP) ? (N_CH'(1) << gid_q) : '0;
    assign grant_id  = gid_q;
    assign busy      = (state_q != ST_IDLE);
    assign proto_err = perr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_slow_mem_arbiter.sv
// Two arbiters (2-channel round-robin, 4-channel fixed priority) under random
// and directed traffic, checked against a transaction-level model.
module tb_slow_mem_arbiter;
    import slow_mem_arb_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int NM = 4;

    typedef struct packed {
        logic [1:0]    ch;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } req_t;

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] data;
    } rsp_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // channel and memory side signals, index 0 = round-robin, 1 = fixed
    logic [NM-1:0] rd [2];
    logic [NM-1:0] wr [2];
    logic [AW-1:0] a  [2][NM];
    logic [DW-1:0] wd [2][NM];
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] mwd [2];
    logic [DW-1:0] mrd [2];
    logic [AW-1:0] maddr [2];
    logic          mread [2];
    logic          mwrite [2];
    logic          mready [2];
    logic          busy [2];
    logic          perr [2];
    logic [1:0]    dbg [2];
    logic [1:0]    rdy0;
    logic [3:0]    rdy1;
    logic [0:0]    gid0;
    logic [1:0]    gid1;
    logic [NM-1:0] rdy [2];
    logic [1:0]    gid [2];

    assign rdy[0] = {2'b00, rdy0};
    assign rdy[1] = rdy1;
    assign gid[0] = {1'b0, gid0};
    assign gid[1] = gid1;

    slow_mem_arbiter #(.N_CH(2), .ADDR_W(AW), .DATA_W(DW), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .ch_read(rd[0][1:0]), .ch_write(wr[0][1:0]),
        .ch_addr({a[0][1], a[0][0]}), .ch_wdata({wd[0][1], wd[0][0]}),
        .ch_rdata(rdata[0]), .ch_ready(rdy0),
        .mem_read(mread[0]), .mem_write(mwrite[0]), .mem_addr(maddr[0]),
        .mem_wdata(mwd[0]), .mem_rdata(mrd[0]), .mem_ready(mready[0]),
        .grant_id(gid0), .busy(busy[0]), .proto_err(perr[0]), .dbg_state(dbg[0])
    );

    slow_mem_arbiter #(.N_CH(4), .ADDR_W(AW), .DATA_W(DW), .MODE(1)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .ch_read(rd[1]), .ch_write(wr[1]),
        .ch_addr({a[1][3], a[1][2], a[1][1], a[1][0]}),
        .ch_wdata({wd[1][3], wd[1][2], wd[1][1], wd[1][0]}),
        .ch_rdata(rdata[1]), .ch_ready(rdy1),
        .mem_read(mread[1]), .mem_write(mwrite[1]), .mem_addr(maddr[1]),
        .mem_wdata(mwd[1]), .mem_rdata(mrd[1]), .mem_ready(mready[1]),
        .grant_id(gid1), .busy(busy[1]), .proto_err(perr[1]), .dbg_state(dbg[1])
    );

    // reference model state (written only by the monitor)
    bit            m_busy [2];
    int            m_cd [2];
    int            m_ptr [2];
    int            m_gid [2];
    bit            m_perr [2];
    logic [DW-1:0] m_last [2];
    req_t          m_req [2];
    logic [DW-1:0] mem [2][64];
    req_t          req_q [2][$];
    rsp_t          rsp_q [2][$];
    bit            prev_req [2];
    int            done_cnt [2][NM];

    // driver state (written only by the main process)
    bit            active [2][NM];
    int            seen_cnt [2][NM];
    bit            armed [2];
    int            lat [2];
    bit            run_rand = 1'b0;
    bit            mem_hold = 1'b0;
    bit            chk_en = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    function automatic int nch(int i);
        return (i == 0) ? 2 : 4;
    endfunction

    task automatic chk(string nm, int i, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic mon(int i);
        logic [NM-1:0] pend;
        req_t          r;
        rsp_t          s;
        int            w;
        int            c;
        bit            in_issue;
        bit            mreq;

        if (m_busy[i] && m_cd[i] > 0) begin
            m_cd[i]--;
            if (m_cd[i] == 0) m_busy[i] = 1'b0;
        end
        in_issue = m_busy[i] && (m_cd[i] == 0);
        mreq = mread[i] | mwrite[i];

        chk("busy", i, busy[i], m_busy[i]);
        chk("proto_err", i, perr[i], m_perr[i]);
        chk("grant_id", i, gid[i], m_gid[i]);
        if (!m_busy[i]) begin
            chk("dbg_idle", i, dbg[i], ST_IDLE);
            chk("rdata_hold", i, rdata[i], m_last[i]);
        end

        chk("mem_req_timing", i, mreq, in_issue);
        if (in_issue && mreq) begin
            chk("mem_addr", i, maddr[i], m_req[i].addr);
            chk("mem_write", i, mwrite[i], m_req[i].wr);
            chk("mem_read", i, mread[i], !m_req[i].wr);
            if (m_req[i].wr) chk("mem_wdata", i, mwd[i], m_req[i].wd);
        end
        if (mreq && !prev_req[i]) begin
            if (req_q[i].size() == 0) begin
                chk("unexpected_mem_req", i, mreq, 1'b0);
            end else begin
                r = req_q[i].pop_front();
                chk("issue_grant", i, gid[i], r.ch);
                chk("issue_addr", i, maddr[i], r.addr);
            end
        end
        prev_req[i] = mreq;

        chk("ready_timing", i, rdy[i] != 0, m_busy[i] && (m_cd[i] == 2));
        if (rdy[i] != 0) begin
            for (int ch = 0; ch < NM; ch++) if (rdy[i][ch]) done_cnt[i][ch]++;
            if (rsp_q[i].size() == 0) begin
                chk("unexpected_ready", i, rdy[i], '0);
            end else begin
                s = rsp_q[i].pop_front();
                chk("ch_ready", i, rdy[i], NM'(1) << s.ch);
                chk("ch_rdata", i, rdata[i], s.data);
            end
        end

        if (mready[i] && in_issue) begin
            r = m_req[i];
            if (r.wr) mem[i][r.addr[5:0]] = r.wd;
            else      m_last[i] = mem[i][r.addr[5:0]];
            s.ch = r.ch;
            s.data = m_last[i];
            rsp_q[i].push_back(s);
            m_cd[i] = 3;
        end

        if (!m_busy[i]) begin
            pend = (rd[i] | wr[i]) & NM'((1 << nch(i)) - 1);
            w = -1;
            for (int off = 0; off < nch(i); off++) begin
                c = (i == 0) ? (m_ptr[i] + off) % nch(i) : off;
                if (pend[c] && w < 0) w = c;
            end
            if (w >= 0) begin
                r.ch = 2'(w);
                r.wr = wr[i][w];
                r.addr = a[i][w];
                r.wd = wd[i][w];
                if (rd[i][w] && wr[i][w]) m_perr[i] = 1'b1;
                m_req[i] = r;
                req_q[i].push_back(r);
                m_busy[i] = 1'b1;
                m_cd[i] = 0;
                m_gid[i] = w;
                if (i == 0) m_ptr[i] = (w + 1) % nch(i);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0; m_cd[i] = 0; m_ptr[i] = 0; m_gid[i] = 0;
                m_perr[i] = 1'b0; m_last[i] = '0; prev_req[i] = 1'b0;
                req_q[i].delete(); rsp_q[i].delete();
                for (int ch = 0; ch < NM; ch++) done_cnt[i][ch] = 0;
                for (int k = 0; k < 64; k++) mem[i][k] = {$urandom, $urandom, $urandom, $urandom};
            end
        end else if (chk_en) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        bit r;
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int ch = 0; ch < nch(i); ch++) begin
                    if (done_cnt[i][ch] != seen_cnt[i][ch]) begin
                        seen_cnt[i][ch] = done_cnt[i][ch];
                        rd[i][ch] = 1'b0; wr[i][ch] = 1'b0; active[i][ch] = 1'b0;
                    end else if (!active[i][ch] && run_rand && $urandom_range(0, 3) == 0) begin
                        r = 1'($urandom_range(0, 1));
                        rd[i][ch] = r; wr[i][ch] = !r;
                        a[i][ch] = AW'($urandom_range(0, 63));
                        wd[i][ch] = {$urandom, $urandom, $urandom, $urandom};
                        active[i][ch] = 1'b1;
                    end else if (active[i][ch] && m_busy[i] && m_cd[i] == 0 &&
                                 int'(m_req[i].ch) == ch && $urandom_range(0, 7) == 0) begin
                        rd[i][ch] = 1'b0; wr[i][ch] = 1'b0;
                    end
                end
                if (mready[i]) begin
                    mready[i] = 1'b0;
                    mrd[i] = {$urandom, $urandom, $urandom, $urandom};
                end else if ((mread[i] || mwrite[i]) && !mem_hold) begin
                    if (!armed[i]) begin
                        lat[i] = $urandom_range(0, 3);
                        armed[i] = 1'b1;
                    end
                    if (lat[i] == 0) begin
                        mready[i] = 1'b1;
                        mrd[i] = mem[i][maddr[i][5:0]];
                        armed[i] = 1'b0;
                    end else begin
                        lat[i]--;
                    end
                end else begin
                    mrd[i] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    endtask

    task automatic issue(int i, int ch, bit r, bit w, logic [AW-1:0] ad, logic [DW-1:0] d);
        rd[i][ch] = r; wr[i][ch] = w; a[i][ch] = ad; wd[i][ch] = d;
        active[i][ch] = 1'b1;
    endtask

    task automatic wait_quiet(string nm);
        bit any;
        any = 1'b1;
        for (int c = 0; c < 400 && any; c++) begin
            step();
            any = m_busy[0] || m_busy[1];
            for (int i = 0; i < 2; i++)
                for (int ch = 0; ch < NM; ch++) any = any || active[i][ch];
        end
        chk(nm, 0, any, 1'b0);
    endtask

    task automatic clear_drivers();
        for (int i = 0; i < 2; i++) begin
            rd[i] = '0; wr[i] = '0; mready[i] = 1'b0; armed[i] = 1'b0; lat[i] = 0;
            mrd[i] = '0;
            for (int ch = 0; ch < NM; ch++) begin
                a[i][ch] = '0; wd[i][ch] = '0; active[i][ch] = 1'b0; seen_cnt[i][ch] = 0;
            end
        end
    endtask

    task automatic check_reset_values();
        for (int i = 0; i < 2; i++) begin
            chk("rst_mem_read", i, mread[i], 1'b0);
            chk("rst_mem_write", i, mwrite[i], 1'b0);
            chk("rst_ch_ready", i, rdy[i], '0);
            chk("rst_busy", i, busy[i], 1'b0);
            chk("rst_proto_err", i, perr[i], 1'b0);
            chk("rst_mem_addr", i, maddr[i], '0);
            chk("rst_mem_wdata", i, mwd[i], '0);
            chk("rst_ch_rdata", i, rdata[i], '0);
            chk("rst_grant_id", i, gid[i], '0);
            chk("rst_state", i, dbg[i], ST_IDLE);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_drivers();
        #12;
        check_reset_values();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        run_rand = 1'b1;
        repeat (1500) step();
        run_rand = 1'b0;
        wait_quiet("random_drain_timeout");

        // single read, write path and readback on the round-robin instance
        step(); issue(0, 0, 1'b1, 1'b0, 28'h0000010, '0);
        wait_quiet("read_timeout");
        step(); issue(0, 1, 1'b0, 1'b1, 28'h0000020, 128'hDEADBEEF);
        wait_quiet("write_timeout");
        step(); issue(0, 0, 1'b1, 1'b0, 28'h0000020, '0);
        wait_quiet("readback_timeout");
        chk("readback_low_word", 0, rdata[0][31:0], 32'hDEADBEEF);

        // both round-robin channels together, then fixed priority ch1 vs ch3
        step();
        issue(0, 0, 1'b1, 1'b0, 28'h3, '0);
        issue(0, 1, 1'b1, 1'b0, 28'h4, '0);
        issue(1, 1, 1'b1, 1'b0, 28'h5, '0);
        issue(1, 3, 1'b0, 1'b1, 28'h6, 128'h1234);
        wait_quiet("pair_timeout");

        // read and write high together on the fixed-priority instance
        step(); issue(1, 0, 1'b1, 1'b1, 28'h7, 128'hCAFE);
        wait_quiet("proto_timeout");
        repeat (5) step();
        chk("proto_err_sticky", 1, perr[1], 1'b1);
        chk("proto_write_done", 1, mem[1][7], 128'hCAFE);

        // reset while both instances sit in ISSUE
        mem_hold = 1'b1;
        step();
        issue(0, 0, 1'b1, 1'b0, 28'h10, '0);
        issue(1, 2, 1'b1, 1'b0, 28'h11, '0);
        for (int c = 0; c < 20 && !(mread[0] && mread[1]); c++) step();
        chk("reached_issue", 0, mread[0] && mread[1], 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        chk_en = 1'b0;
        #1;
        check_reset_values();
        clear_drivers();
        mem_hold = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (20) step();

        for (int i = 0; i < 2; i++) begin
            chk("req_q_empty", i, req_q[i].size(), 0);
            chk("rsp_q_empty", i, rsp_q[i].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
